// File: rtl/clint_timer_pkg.sv
// Shared constants and helpers for the CLINT machine timer: address map,
// decode result type and the byte-merge used by partial stores.
package clint_timer_pkg;

    localparam logic [63:0] CLINT_BASE   = 64'h0000_0000_0200_0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    typedef struct packed {
        logic hit;
        logic sel_cmp;
        logic sel_time;
        logic err;
    } dec_t;

    // Replace only the bytes whose strobe is set; strobe 0 leaves old_val intact.
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: owns mtime/mtimecmp, answers 64-bit bus accesses in the CLINT
// window and drives the registered level interrupt mtime >= mtimecmp.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = CLINT_BASE,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        req_hit,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        timer_int_o,
    output logic [0:0]  o_dbg_state
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [0:0] TMR_IDLE = 1'b0;
    localparam logic [0:0] TMR_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_int;
    logic [63:0]      r_rdata;
    logic             r_err;

    logic [63:0]      w_off;
    dec_t             w_dec;
    logic             w_accept;
    logic             w_tick;
    logic             w_wr_time;
    logic             w_wr_cmp;
    logic [63:0]      w_rd_val;

    // Address decode: misaligned addresses never select a register.
    assign w_off            = req_addr - BASE_ADDR;
    assign w_dec.hit        = (w_off[63:16] == 48'd0);
    assign w_dec.sel_cmp    = w_dec.hit && (w_off[15:0] == MTIMECMP_OFF) && (req_addr[2:0] == 3'd0);
    assign w_dec.sel_time   = w_dec.hit && (w_off[15:0] == MTIME_OFF) && (req_addr[2:0] == 3'd0);
    assign w_dec.err        = !(w_dec.sel_cmp || w_dec.sel_time);

    assign req_hit = w_dec.hit;

    // Handshake: a request transfers when req_valid && req_ready; a response
    // transfers when resp_valid && resp_ready. While a response waits, a new
    // request is only taken on the same edge that the old response is consumed.
    assign req_ready = (r_state == TMR_IDLE) || resp_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_wr_time = w_accept && req_wen && w_dec.sel_time;
    assign w_wr_cmp  = w_accept && req_wen && w_dec.sel_cmp;

    always_comb begin
        w_rd_val = 64'd0;
        if (!req_wen && w_dec.sel_time) begin
            w_rd_val = r_mtime;
        end else if (!req_wen && w_dec.sel_cmp) begin
            w_rd_val = r_mtimecmp;
        end
    end

    // Prescaler and mtime; a store to mtime overrides a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime   <= 64'd0;
            r_div_cnt <= '0;
        end else if (w_wr_time) begin
            r_mtime   <= merge_bytes(r_mtime, req_wdata, req_wstrb);
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_mtime   <= r_mtime + 64'd1;
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_wr_cmp) begin
            r_mtimecmp <= merge_bytes(r_mtimecmp, req_wdata, req_wstrb);
        end
    end

    // Compares the current register values, so it trails any update by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int <= 1'b0;
        end else begin
            r_int <= (r_mtime >= r_mtimecmp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TMR_IDLE;
        end else begin
            case (r_state)
                TMR_IDLE: begin
                    if (w_accept) begin
                        r_state <= TMR_RESP;
                    end
                end
                TMR_RESP: begin
                    if (!w_accept && resp_ready) begin
                        r_state <= TMR_IDLE;
                    end
                end
                default: r_state <= TMR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_rd_val;
            r_err   <= w_dec.err;
        end
    end

    assign resp_valid  = (r_state == TMR_RESP);
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign timer_int_o = r_int;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) share one stimulus
// stream and are checked every cycle against an architectural model.
module tb_clint_timer;

    localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_CMP    = BASE + 64'h4000;
    localparam logic [63:0] A_TIME   = BASE + 64'hBFF8;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_ready;

    logic [1:0]  rdy;
    logic [1:0]  hit;
    logic [1:0]  rv;
    logic [1:0]  err;
    logic [1:0]  ti;
    logic [1:0]  dbg;
    logic [63:0] rdata [2];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_hit(hit[0]), .resp_valid(rv[0]),
        .resp_ready(resp_ready), .resp_rdata(rdata[0]), .resp_err(err[0]),
        .timer_int_o(ti[0]), .o_dbg_state(dbg[0:0])
    );

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_hit(hit[1]), .resp_valid(rv[1]),
        .resp_ready(resp_ready), .resp_rdata(rdata[1]), .resp_err(err[1]),
        .timer_int_o(ti[1]), .o_dbg_state(dbg[1:1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- architectural model ----------------
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    int          m_div   [2];
    logic        m_int   [2];
    logic        m_rv    [2];
    logic        m_err   [2];
    logic [63:0] m_rdata [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic in_window(input logic [63:0] a);
        return (a >= BASE) && (a <= BASE + 64'hFFFF);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        logic acc, is_t, is_c;
        logic [63:0] nt, nc;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mtime[i] = 64'd0; m_cmp[i] = ONES; m_div[i] = 0;
                m_int[i] = 1'b0; m_rv[i] = 1'b0; m_err[i] = 1'b0; m_rdata[i] = 64'd0;
            end else begin
                acc  = req_valid && (!m_rv[i] || resp_ready);
                is_t = (req_addr == A_TIME);
                is_c = (req_addr == A_CMP);
                nt = m_mtime[i];
                nc = m_cmp[i];
                m_int[i] = (m_mtime[i] >= m_cmp[i]);
                if (acc) begin
                    m_rv[i]    = 1'b1;
                    m_err[i]   = !(is_t || is_c);
                    m_rdata[i] = (req_wen || m_err[i]) ? 64'd0 : (is_t ? m_mtime[i] : m_cmp[i]);
                end else if (resp_ready) begin
                    m_rv[i] = 1'b0;
                end
                if (acc && req_wen && is_t) begin
                    nt = merge(nt, req_wdata, req_wstrb);
                    m_div[i] = 0;
                end else if (m_div[i] == div_of(i) - 1) begin
                    nt = nt + 64'd1;
                    m_div[i] = 0;
                end else begin
                    m_div[i] = m_div[i] + 1;
                end
                if (acc && req_wen && is_c) nc = merge(nc, req_wdata, req_wstrb);
                m_mtime[i] = nt;
                m_cmp[i]   = nc;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d req_ready", i), 64'(rdy[i]), 64'(!m_rv[i] || resp_ready));
                chk($sformatf("d%0d req_hit", i), 64'(hit[i]), 64'(in_window(req_addr)));
                chk($sformatf("d%0d resp_valid", i), 64'(rv[i]), 64'(m_rv[i]));
                chk($sformatf("d%0d timer_int", i), 64'(ti[i]), 64'(m_int[i]));
                if (m_rv[i]) begin
                    chk($sformatf("d%0d resp_rdata", i), rdata[i], m_rdata[i]);
                    chk($sformatf("d%0d resp_err", i), 64'(err[i]), 64'(m_err[i]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [63:0] c_rdata [2];
    logic [1:0]  c_err;
    logic [1:0]  c_ti;

    // Presents one request, waits for acceptance, captures the response on the
    // following negedge and returns at posedge+2 of the next cycle.
    task automatic xact(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wstrb, output int acc);
        int guard;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        guard = 0;
        @(negedge clk);
        while (!rdy[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[0]) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready stayed 0, required 1");
        end
        acc = cyc + 1;
        @(posedge clk); #2;
        req_valid = 1'b0; req_wen = 1'b0;
        @(negedge clk);
        c_rdata[0] = rdata[0]; c_rdata[1] = rdata[1];
        c_err = err; c_ti = ti;
        @(posedge clk); #2;
    endtask

    // ---------------- directed sequence ----------------
    int a0, a1, b, w, t, rise_cyc, tmp;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = BASE;
        req_wdata = 64'd0; req_wstrb = 8'h00; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", 64'(rv[0]), 64'd0);
        chk("reset resp_rdata", rdata[0], 64'd0);
        chk("reset resp_err", 64'(err[0]), 64'd0);
        chk("reset timer_int", 64'(ti[0]), 64'd0);
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;

        // Ten ticks since reset: div1 counts 10, div4 has ticked twice.
        xact(1'b0, A_TIME, 64'd0, 8'h00, tmp);
        chk("idle mtime div1", c_rdata[0], 64'd10);
        chk("idle mtime div4", c_rdata[1], 64'd2);

        xact(1'b1, A_CMP, 64'hAAAA_BBBB_1234_5678, 8'h0F, tmp);
        xact(1'b0, A_CMP, 64'd0, 8'h00, tmp);
        chk("partial mtimecmp", c_rdata[0], 64'hFFFF_FFFF_1234_5678);

        // mtime reaches 20 at edge a0+20; the interrupt follows one edge later.
        xact(1'b1, A_TIME, 64'd0, 8'hFF, a0);
        xact(1'b1, A_CMP, 64'd20, 8'hFF, a1);
        rise_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ti[0]) begin
                rise_cyc = cyc;
                break;
            end
        end
        chk("int rise cycle", 64'(rise_cyc), 64'(a0 + 21));
        @(posedge clk); #2;

        xact(1'b1, A_CMP, 64'd1000, 8'hFF, b);
        chk("int before cmp raise", 64'(c_ti[0]), 64'd1);
        @(negedge clk);
        chk("int after cmp raise", 64'(ti[0]), 64'd0);
        @(posedge clk); #2;

        xact(1'b1, A_CMP, ONES, 8'hFF, tmp);
        xact(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, w);
        @(negedge clk);
        chk("wrap int at FFFE", 64'(ti[0]), 64'd0);
        @(negedge clk);
        chk("wrap int at FFFF", 64'(ti[0]), 64'd1);
        @(negedge clk);
        chk("wrap int at 0", 64'(ti[0]), 64'd0);
        @(posedge clk); #2;

        xact(1'b0, BASE + 64'h4004, 64'd0, 8'h00, tmp);
        chk("err 4004 resp_err", 64'(c_err[0]), 64'd1);
        chk("err 4004 resp_rdata", c_rdata[0], 64'd0);
        xact(1'b1, BASE, 64'h1234, 8'hFF, tmp);
        chk("err 0000 resp_err", 64'(c_err[0]), 64'd1);
        chk("err 0000 resp_rdata", c_rdata[0], 64'd0);
        xact(1'b0, A_CMP, 64'd0, 8'h00, tmp);
        chk("cmp unchanged", c_rdata[0], ONES);

        // Align the div4 store with a tick edge.
        for (int k = 0; k < 8 && m_div[1] != 3; k++) begin
            @(posedge clk); #2;
        end
        xact(1'b1, A_TIME, 64'd100, 8'hFF, t);
        xact(1'b0, A_TIME, 64'd0, 8'h00, tmp);
        chk("div4 store over tick", c_rdata[1], 64'd100);
        xact(1'b0, A_TIME, 64'd0, 8'h00, tmp);
        chk("div4 before next tick", c_rdata[1], 64'd100);
        xact(1'b0, A_TIME, 64'd0, 8'h00, tmp);
        chk("div4 after next tick", c_rdata[1], 64'd101);

        // Backpressure: hold the response, then release for a back-to-back accept.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = A_CMP;
        @(posedge clk); #2;
        req_addr = BASE + 64'h0008;
        repeat (5) begin
            @(negedge clk);
            chk("hold req_ready", 64'(rdy[0]), 64'd0);
            chk("hold resp_valid", 64'(rv[0]), 64'd1);
            chk("hold resp_rdata", rdata[0], ONES);
        end
        @(posedge clk); #2;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("release req_ready", 64'(rdy[0]), 64'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b resp_valid", 64'(rv[0]), 64'd1);
        chk("b2b resp_err", 64'(err[0]), 64'd1);
        chk("b2b resp_rdata", rdata[0], 64'd0);
        @(negedge clk);
        chk("drain resp_valid", 64'(rv[0]), 64'd0);
        @(posedge clk); #2;

        // Reset while a response is pending drops it.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = A_TIME;
        @(posedge clk); #2;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pending resp_valid", 64'(rv[0]), 64'd1);
        @(negedge clk);
        chk("reset drops resp", 64'(rv[0]), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0; resp_ready = 1'b1;
        xact(1'b0, A_CMP, 64'd0, 8'h00, tmp);
        chk("cmp after reset", c_rdata[0], ONES);

        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
